// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Valid/ready stream carrying a control and a data payload.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) ();
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input  ready);
    modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Two-entry (main + skid) pipeline stage with registered ready,
//               flush and bubble control encoding.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  wire                  clk,
    input  wire                  reset,
    input  wire                  flush,
    pipe_stage_reg_if.slave      in_if,
    pipe_stage_reg_if.master     out_if,
    output logic [1:0]           occupancy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state      = S_EMPTY;
    logic              r_in_ready   = 1'b1;
    logic              r_main_valid = 1'b0;
    logic [CTRL_W-1:0] r_main_ctrl  = CTRL_RST;
    logic [DATA_W-1:0] r_main_data  = '0;
    logic              r_skid_valid = 1'b0;
    logic [CTRL_W-1:0] r_skid_ctrl  = CTRL_RST;
    logic [DATA_W-1:0] r_skid_data  = '0;

    state_t            w_state;
    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic              w_accept;
    logic              w_drain;

    assign w_accept = in_if.valid && r_in_ready;
    assign w_drain  = r_main_valid && out_if.ready;

    always_comb begin
        w_state      = r_state;
        w_main_valid = r_main_valid;
        w_main_ctrl  = r_main_ctrl;
        w_main_data  = r_main_data;
        w_skid_valid = r_skid_valid;
        w_skid_ctrl  = r_skid_ctrl;
        w_skid_data  = r_skid_data;

        if (flush) begin
            // Data registers are left alone; only validity and control are killed.
            w_state      = S_EMPTY;
            w_main_valid = 1'b0;
            w_main_ctrl  = CTRL_RST;
            w_skid_valid = 1'b0;
            w_skid_ctrl  = CTRL_RST;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state      = S_ONE;
                        w_main_valid = 1'b1;
                        w_main_ctrl  = in_if.ctrl;
                        w_main_data  = in_if.data;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_drain) begin
                        w_main_ctrl = in_if.ctrl;
                        w_main_data = in_if.data;
                    end else if (w_accept) begin
                        w_state      = S_FULL;
                        w_skid_valid = 1'b1;
                        w_skid_ctrl  = in_if.ctrl;
                        w_skid_data  = in_if.data;
                    end else if (w_drain) begin
                        w_state      = S_EMPTY;
                        w_main_valid = 1'b0;
                        w_main_ctrl  = CTRL_RST;
                    end
                end
                S_FULL: begin
                    // Oldest entry sits in main; the skid entry is promoted behind it.
                    if (w_drain) begin
                        w_state      = S_ONE;
                        w_main_valid = 1'b1;
                        w_main_ctrl  = r_skid_ctrl;
                        w_main_data  = r_skid_data;
                        w_skid_valid = 1'b0;
                        w_skid_ctrl  = CTRL_RST;
                    end
                end
                default: begin
                    w_state      = S_EMPTY;
                    w_main_valid = 1'b0;
                    w_main_ctrl  = CTRL_RST;
                    w_skid_valid = 1'b0;
                    w_skid_ctrl  = CTRL_RST;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_EMPTY;
            r_in_ready   <= 1'b1;
            r_main_valid <= 1'b0;
            r_main_ctrl  <= CTRL_RST;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= CTRL_RST;
            r_skid_data  <= '0;
        end else begin
            r_state      <= w_state;
            r_in_ready   <= (w_state != S_FULL);
            r_main_valid <= w_main_valid;
            r_main_ctrl  <= w_main_ctrl;
            r_main_data  <= w_main_data;
            r_skid_valid <= w_skid_valid;
            r_skid_ctrl  <= w_skid_ctrl;
            r_skid_data  <= w_skid_data;
        end
    end

    assign in_if.ready  = r_in_ready;
    assign out_if.valid = r_main_valid;
    assign out_if.ctrl  = r_main_ctrl;
    assign out_if.data  = r_main_data;
    assign occupancy    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Scoreboard bench for pipe_stage_reg with directed and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int                DATA_W   = 32;
    localparam int                CTRL_W   = 8;
    localparam logic [CTRL_W-1:0] CTRL_RST = 8'hA5;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] occupancy;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up_if ();
    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn_if ();

    pipe_stage_reg #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_RST (CTRL_RST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_if     (up_if.slave),
        .out_if    (dn_if.master),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Reference model: the stage is simply an in-order FIFO of at most two entries.
    entry_t sb[$];
    entry_t mon_e;
    int     n_cmp    = 0;
    int     n_err    = 0;
    bit     rst_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input bit ordy, input bit fl, input bit rs);
        @(negedge clk);
        chk("occupancy", 64'(occupancy), 64'(sb.size()));
        chk("in_ready",  64'(up_if.ready), 64'(sb.size() < 2));
        chk("out_valid", 64'(dn_if.valid), 64'(sb.size() > 0));
        if (sb.size() == 0) chk("bubble_ctrl", 64'(dn_if.ctrl), 64'(CTRL_RST));
        if (rst_prev)       chk("reset_data",  64'(dn_if.data), 64'd0);
        up_if.valid = v;
        up_if.data  = d;
        up_if.ctrl  = c;
        dn_if.ready = ordy;
        flush       = fl;
        reset       = rs;
        rst_prev    = rs;
        if (v && sb.size() < 2 && !fl && !rs) sb.push_back({c, d});
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, '0, '0, ordy, 1'b0, 1'b0);
    endtask

    // Monitor: pops the scoreboard whenever the stage hands an entry downstream.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                sb.delete();
            end else begin
                if (dn_if.valid && dn_if.ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_output: got %0h expected none at %0t",
                                 {dn_if.ctrl, dn_if.data}, $time);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("out_entry", 64'({dn_if.ctrl, dn_if.data}), 64'(mon_e));
                    end
                end
                if (flush) sb.delete();
            end
        end
    end

    initial begin
        up_if.valid = 1'b0;
        up_if.data  = '0;
        up_if.ctrl  = '0;
        dn_if.ready = 1'b0;
        #1;
        chk("t0_occupancy", 64'(occupancy),  64'd0);
        chk("t0_out_valid", 64'(dn_if.valid), 64'd0);
        chk("t0_out_ctrl",  64'(dn_if.ctrl),  64'(CTRL_RST));

        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);

        // Streaming at full rate
        cycle(1'b1, 32'h11, 8'h01, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 8'h02, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h33, 8'h03, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Backpressure fills the skid; third push must be refused
        cycle(1'b1, 32'hA, 8'h0A, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 8'h0B, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 8'h0C, 1'b0, 1'b0, 1'b0);
        chk("held_data", 64'(dn_if.data), 64'hA);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush while full, with a simultaneous push that must vanish
        cycle(1'b1, 32'h1, 8'h11, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h2, 8'h12, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hD, 8'h0D, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Accept and drain together while holding one entry
        cycle(1'b1, 32'h44, 8'h44, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h55, 8'h55, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("pass_through_data", 64'(dn_if.data), 64'h55);
        idle(1'b1);

        // Reset and flush together while full
        cycle(1'b1, 32'h66, 8'h66, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h77, 8'h77, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h88, 8'h88, 1'b0, 1'b1, 1'b1);
        idle(1'b0);
        idle(1'b1);

        for (int i = 0; i < 10000; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom, 8'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 299) == 0);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the data payload (operands, immediates, ALU result, register IDs).
REQ-002 Parameter CTRL_W, default 8, width of the control payload (RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUop and similar).
REQ-003 Parameter CTRL_RST, default all-zero CTRL_W vector, control value presented while empty, flushed or in reset (bubble encoding).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous kill of every entry held in the stage.
REQ-007 in_valid  input  1  upstream presents a valid entry.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 in_ctrl  input  CTRL_W  upstream control payload.
REQ-010 in_data  input  DATA_W  upstream data payload.
REQ-011 out_valid  output  1  stage presents a valid entry.
REQ-012 out_ready  input  1  downstream accepts the presented entry this cycle.
REQ-013 out_ctrl  output  CTRL_W  presented control payload.
REQ-014 out_data  output  DATA_W  presented data payload.
REQ-015 occupancy  output  2  number of held entries: 0, 1 or 2.

Function
REQ-016 Storage: two entries, a main register (drives outputs) and a skid register; each holds a valid bit, ctrl and data.
REQ-017 States: EMPTY (occupancy 0), ONE (1), FULL (2); occupancy is the state encoding.
REQ-018 Input handshake: an accept occurs when in_valid && in_ready. Output handshake: a drain occurs when out_valid && out_ready.
REQ-019 in_ready is 1 in EMPTY and ONE and 0 in FULL, and it comes from a register only, with no combinational path from out_ready.
REQ-020 out_valid is 1 in ONE and FULL and 0 in EMPTY.
REQ-021 Transitions without flush: EMPTY+accept->ONE; ONE+accept+no drain->FULL; ONE+drain+no accept->EMPTY; ONE+accept+drain->ONE; FULL+drain->ONE; all other cases hold the current state.
REQ-022 Latency: an entry accepted in EMPTY appears on out_* in the next cycle; sustained throughput is 1 entry/cycle when out_ready=1.
REQ-023 Ordering: entries leave in acceptance order; in FULL the main register drains first and the skid entry then moves into main.
REQ-024 ONE with simultaneous accept and drain: the new entry loads directly into main and the skid register stays empty.
REQ-025 While out_valid=0, out_ctrl SHALL equal CTRL_RST, so an empty stage is a bubble for downstream control decode.
REQ-026 Held entries SHALL keep out_ctrl and out_data stable while out_valid=1 and out_ready=0.
REQ-027 Flush: on the next edge both valid bits clear, state goes to EMPTY and both ctrl registers load CTRL_RST; data registers keep their values.
REQ-028 Flush priority: an accept in the same cycle as flush is discarded, and a drain in that cycle still counts downstream.
REQ-029 There is no wrap-around: the stage never holds more than 2 entries, and an in_valid offered in FULL is not accepted, with no state change.

Reset
REQ-030 With reset=1 at a clock edge, next cycle: state EMPTY, occupancy=0, out_valid=0, in_ready=1, out_ctrl=CTRL_RST, out_data=0, skid contents zero.
REQ-031 Reset has priority over flush, accept and drain; reset asserted mid-transfer discards all held entries.
REQ-032 Registers start at the reset values at time zero so simulation is deterministic before the first reset.

Verification
REQ-033 Reset, then in_valid=1 with data 0x11,0x22,0x33 on consecutive cycles and out_ready=1 -> out_data 0x11,0x22,0x33 one cycle later each; occupancy stays 1; in_ready stays 1.
REQ-034 out_ready=0, push 0xA and 0xB -> occupancy 2, in_ready=0, out_data=0xA held; third push 0xC ignored; then out_ready=1 -> 0xA, 0xB in order, occupancy 2->1->0.
REQ-035 Occupancy 2, flush=1 together with in_valid=1 (data 0xD) -> next cycle occupancy 0, out_valid=0, out_ctrl=CTRL_RST; 0xD never appears.
REQ-036 Occupancy 1, in_valid=1 and out_ready=1 in the same cycle -> occupancy remains 1 and out_data is the new entry next cycle.
REQ-037 Occupancy 2, reset=1 and flush=1 together -> outputs match REQ-030 exactly, including out_data=0.
REQ-038 Random in_valid/out_ready/flush for 10k cycles against a reference queue model -> no loss, duplication or reorder of unflushed entries, and out_ctrl=CTRL_RST whenever out_valid=0.
